// File: rtl/sap2_mini_pkg.sv
// rtl/sap2_mini_pkg.sv - shared constants for the SAP-2 mini controller-sequencer
package sap2_mini_pkg;

  localparam int CW_WIDTH = 16;
  localparam int T_NUM    = 6;

  // Opcode nibble as presented by the instruction register
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit positions; _N marks active-low loads
  localparam int CW_CP   = 0;
  localparam int CW_EP   = 1;
  localparam int CW_LM_N = 2;
  localparam int CW_CE   = 3;
  localparam int CW_LI_N = 4;
  localparam int CW_EI   = 5;
  localparam int CW_LA_N = 6;
  localparam int CW_EA   = 7;
  localparam int CW_SU   = 8;
  localparam int CW_EU   = 9;
  localparam int CW_LB_N = 10;
  localparam int CW_LO_N = 11;
  localparam int CW_J    = 12;
  localparam int CW_WE   = 13;
  localparam int CW_FI   = 14;
  localparam int CW_HLT  = 15;

  // Everything inactive: active-low loads sit high, all else low
  localparam logic [CW_WIDTH-1:0] CW_IDLE = 16'h0C54;

  // One-hot T-states
  localparam logic [T_NUM-1:0] T1 = 6'b000001;
  localparam logic [T_NUM-1:0] T2 = 6'b000010;
  localparam logic [T_NUM-1:0] T3 = 6'b000100;
  localparam logic [T_NUM-1:0] T4 = 6'b001000;
  localparam logic [T_NUM-1:0] T5 = 6'b010000;
  localparam logic [T_NUM-1:0] T6 = 6'b100000;

  // Assert one control signal, honouring its polarity (active-low bits are the ones high in CW_IDLE)
  function automatic logic [CW_WIDTH-1:0] cw_on(input logic [CW_WIDTH-1:0] cw, input int idx);
    logic [CW_WIDTH-1:0] m;
    m = 16'h0001 << idx;
    return ((CW_IDLE & m) != 16'h0000) ? (cw & ~m) : (cw | m);
  endfunction

endpackage

// File: rtl/sap2_mini_ring.sv
// rtl/sap2_mini_ring.sv - one-hot T-state ring counter with hold and restart
module sap2_mini_ring #(
  parameter int T_N = 6
) (
  input  logic           clk_i,
  input  logic           clr_i,
  input  logic           hold_i,
  input  logic           restart_i,
  output logic [T_N-1:0] t_state_o
);

  localparam logic [T_N-1:0] T_FIRST = {{(T_N-1){1'b0}}, 1'b1};

  logic [T_N-1:0] state_q;
  logic [T_N-1:0] state_d;
  logic           onehot;

  // Next state: bad encodings recover to T1; hold beats restart so a stalled last state delays the wrap
  always_comb begin
    state_d = state_q;
    onehot  = (state_q != '0) && ((state_q & (state_q - T_FIRST)) == '0);
    if (!onehot) begin
      state_d = T_FIRST;
    end else if (hold_i) begin
      state_d = state_q;
    end else if (restart_i) begin
      state_d = T_FIRST;
    end else begin
      state_d = {state_q[T_N-2:0], state_q[T_N-1]};
    end
  end

  // State register; clr wins over everything
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= T_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  assign t_state_o = state_q;

endmodule

// File: rtl/sap2_mini_ctrl.sv
// rtl/sap2_mini_ctrl.sv - SAP-2 mini control word decoder and sequencer top
module sap2_mini_ctrl
  import sap2_mini_pkg::*;
#(
  parameter int CW_W = 16,
  parameter int T_N  = 6
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [3:0]      opcode,
  input  logic            flag_z,
  input  logic            flag_c,
  input  logic            mem_rdy,
  output logic [CW_W-1:0] cw,
  output logic [T_N-1:0]  t_state,
  output logic            halted
);

  logic                hold;
  logic                restart;
  logic                halted_q;
  logic                halted_d;
  logic [CW_W-1:0]     cw_c;

  sap2_mini_ring #(.T_N(T_N)) u_ring (
    .clk_i     (clk),
    .clr_i     (clr),
    .hold_i    (hold),
    .restart_i (restart),
    .t_state_o (t_state)
  );

  // Decode control word, stall/halt hold and end-of-instruction from the current T-state
  always_comb begin
    cw_c     = CW_IDLE;
    hold     = 1'b0;
    restart  = 1'b0;
    halted_d = halted_q;
    if (clr) begin
      cw_c = CW_IDLE;
    end else if (halted_q) begin
      cw_c = cw_on(CW_IDLE, CW_HLT);
      hold = 1'b1;
    end else begin
      case (t_state)
        T1: cw_c = cw_on(cw_on(CW_IDLE, CW_EP), CW_LM_N);
        T2: cw_c = cw_on(CW_IDLE, CW_CP);
        T3: begin
          cw_c = cw_on(cw_on(CW_IDLE, CW_CE), CW_LI_N);
          hold = !mem_rdy;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA:
              cw_c = cw_on(cw_on(CW_IDLE, CW_EI), CW_LM_N);
            OP_LDI: begin
              cw_c    = cw_on(cw_on(CW_IDLE, CW_EI), CW_LA_N);
              restart = 1'b1;
            end
            OP_JMP: begin
              cw_c    = cw_on(cw_on(CW_IDLE, CW_EI), CW_J);
              restart = 1'b1;
            end
            OP_JC: begin
              if (flag_c) cw_c = cw_on(cw_on(CW_IDLE, CW_EI), CW_J);
              restart = 1'b1;
            end
            OP_JZ: begin
              if (flag_z) cw_c = cw_on(cw_on(CW_IDLE, CW_EI), CW_J);
              restart = 1'b1;
            end
            OP_OUT: begin
              cw_c    = cw_on(cw_on(CW_IDLE, CW_EA), CW_LO_N);
              restart = 1'b1;
            end
            OP_HLT: begin
              cw_c     = cw_on(CW_IDLE, CW_HLT);
              hold     = 1'b1;
              halted_d = 1'b1;
            end
            default: restart = 1'b1;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              cw_c    = cw_on(cw_on(CW_IDLE, CW_CE), CW_LA_N);
              hold    = !mem_rdy;
              restart = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw_c = cw_on(cw_on(CW_IDLE, CW_CE), CW_LB_N);
              hold = !mem_rdy;
            end
            OP_STA: begin
              cw_c    = cw_on(cw_on(CW_IDLE, CW_EA), CW_WE);
              hold    = !mem_rdy;
              restart = 1'b1;
            end
            default: restart = 1'b1;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw_c = cw_on(cw_on(cw_on(CW_IDLE, CW_EU), CW_LA_N), CW_FI);
            if (opcode == OP_SUB) cw_c = cw_on(cw_c, CW_SU);
          end
          restart = 1'b1;
        end
        default: cw_c = CW_IDLE;
      endcase
    end
  end

  // Halt flag register; only clr releases it
  always_ff @(posedge clk) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign cw     = cw_c;
  assign halted = halted_q;

endmodule

// File: tb/tb_sap2_mini_ctrl.sv
// tb/tb_sap2_mini_ctrl.sv - table-driven self-checking bench for sap2_mini_ctrl
module tb_sap2_mini_ctrl;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  localparam logic [15:0] C_IDLE = 16'h0C54;
  localparam logic [15:0] C_T1   = 16'h0C52;
  localparam logic [15:0] C_T2   = 16'h0C55;
  localparam logic [15:0] C_T3   = 16'h0C4C;
  localparam logic [15:0] C_EIM  = 16'h0C70;
  localparam logic [15:0] C_LDA5 = 16'h0C1C;
  localparam logic [15:0] C_ADD5 = 16'h085C;
  localparam logic [15:0] C_ADD6 = 16'h4E14;
  localparam logic [15:0] C_SUB6 = 16'h4F14;
  localparam logic [15:0] C_STA5 = 16'h2CD4;
  localparam logic [15:0] C_LDI4 = 16'h0C34;
  localparam logic [15:0] C_JMP4 = 16'h1C74;
  localparam logic [15:0] C_OUT4 = 16'h04D4;
  localparam logic [15:0] C_HLT  = 16'h8C54;

  typedef struct {
    logic        clr;
    logic [3:0]  op;
    logic        fz;
    logic        fc;
    logic        rdy;
    logic [5:0]  t;
    logic [15:0] cw;
    logic        h;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  opcode;
  logic        flag_z;
  logic        flag_c;
  logic        mem_rdy;
  logic [15:0] cw;
  logic [5:0]  t_state;
  logic        halted;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sap2_mini_ctrl dut (
    .clk     (clk),
    .clr     (clr),
    .opcode  (opcode),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .mem_rdy (mem_rdy),
    .cw      (cw),
    .t_state (t_state),
    .halted  (halted)
  );

  function automatic vec_t mk(input logic c, input logic [3:0] op, input logic fz, input logic fc,
                              input logic rdy, input logic [5:0] t, input logic [15:0] cwe, input logic h);
    vec_t r;
    r.clr = c; r.op = op; r.fz = fz; r.fc = fc; r.rdy = rdy; r.t = t; r.cw = cwe; r.h = h;
    return r;
  endfunction

  task automatic ex(input logic [3:0] op, input logic fz, input logic fc, input logic rdy,
                    input logic [5:0] t, input logic [15:0] cwe);
    vt.push_back(mk(1'b0, op, fz, fc, rdy, t, cwe, 1'b0));
  endtask

  task automatic fetch(input logic [3:0] op);
    ex(op, 1'b0, 1'b0, 1'b1, S1, C_T1);
    ex(op, 1'b0, 1'b0, 1'b1, S2, C_T2);
    ex(op, 1'b0, 1'b0, 1'b1, S3, C_T3);
  endtask

  task automatic apply(input vec_t r, input int idx);
    @(negedge clk);
    clr = r.clr; opcode = r.op; flag_z = r.fz; flag_c = r.fc; mem_rdy = r.rdy;
    #1;
    n_cmp++;
    if (t_state !== r.t) begin
      n_bad++;
      $display("FAIL vec%0d t_state: got %b want %b", idx, t_state, r.t);
    end
    n_cmp++;
    if (cw !== r.cw) begin
      n_bad++;
      $display("FAIL vec%0d cw: got %h want %h", idx, cw, r.cw);
    end
    n_cmp++;
    if (halted !== r.h) begin
      n_bad++;
      $display("FAIL vec%0d halted: got %b want %b", idx, halted, r.h);
    end
  endtask

  initial begin
    clr = 1'b1; opcode = 4'h0; flag_z = 1'b0; flag_c = 1'b0; mem_rdy = 1'b1;
    @(posedge clk);

    // reset held for two more edges
    vt.push_back(mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, S1, C_IDLE, 1'b0));
    vt.push_back(mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, S1, C_IDLE, 1'b0));
    // LDI, NOP, LDA, ADD, SUB
    fetch(4'h5); ex(4'h5, 0, 0, 1, S4, C_LDI4);
    fetch(4'h0); ex(4'h0, 0, 0, 1, S4, C_IDLE);
    fetch(4'h1); ex(4'h1, 0, 0, 1, S4, C_EIM); ex(4'h1, 0, 0, 1, S5, C_LDA5);
    fetch(4'h2); ex(4'h2, 0, 0, 1, S4, C_EIM); ex(4'h2, 0, 0, 1, S5, C_ADD5); ex(4'h2, 0, 0, 1, S6, C_ADD6);
    fetch(4'h3); ex(4'h3, 0, 0, 1, S4, C_EIM); ex(4'h3, 0, 0, 1, S5, C_ADD5); ex(4'h3, 0, 0, 1, S6, C_SUB6);
    // conditional jumps both ways, cross flags ignored
    fetch(4'h7); ex(4'h7, 0, 1, 1, S4, C_JMP4);
    fetch(4'h7); ex(4'h7, 1, 0, 1, S4, C_IDLE);
    fetch(4'h8); ex(4'h8, 1, 0, 1, S4, C_JMP4);
    fetch(4'h8); ex(4'h8, 0, 1, 1, S4, C_IDLE);
    fetch(4'h6); ex(4'h6, 0, 0, 1, S4, C_JMP4);
    fetch(4'hE); ex(4'hE, 0, 0, 1, S4, C_OUT4);
    fetch(4'hB); ex(4'hB, 1, 1, 1, S4, C_IDLE);
    // T3 stall; mem_rdy ignored in T1/T2/T4; stall in LDA's final state
    ex(4'h1, 0, 0, 0, S1, C_T1); ex(4'h1, 0, 0, 0, S2, C_T2);
    ex(4'h1, 0, 0, 0, S3, C_T3); ex(4'h1, 0, 0, 1, S3, C_T3);
    ex(4'h1, 0, 0, 0, S4, C_EIM);
    ex(4'h1, 0, 0, 0, S5, C_LDA5); ex(4'h1, 0, 0, 1, S5, C_LDA5);
    // STA with three stalled edges in T5, WE held
    fetch(4'h4); ex(4'h4, 0, 0, 1, S4, C_EIM);
    for (int k = 0; k < 3; k++) ex(4'h4, 0, 0, 0, S5, C_STA5);
    ex(4'h4, 0, 0, 1, S5, C_STA5);
    // ADD with one T5 stall; T6 ignores mem_rdy and flags
    fetch(4'h2); ex(4'h2, 0, 0, 1, S4, C_EIM);
    ex(4'h2, 0, 0, 0, S5, C_ADD5); ex(4'h2, 0, 0, 1, S5, C_ADD5);
    ex(4'h2, 1, 1, 0, S6, C_ADD6);

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // HLT: freeze at T4 for ten clocks, then clr releases
    apply(mk(0, 4'hF, 0, 0, 1, S1, C_T1, 0), 1000);
    apply(mk(0, 4'hF, 0, 0, 1, S2, C_T2, 0), 1001);
    apply(mk(0, 4'hF, 0, 0, 1, S3, C_T3, 0), 1002);
    apply(mk(0, 4'hF, 0, 0, 1, S4, C_HLT, 0), 1003);
    for (int k = 0; k < 10; k++) begin
      apply(mk(0, 4'hF, k[0], k[1], k[2], S4, C_HLT, 1), 1010 + k);
    end
    apply(mk(1, 4'hF, 0, 0, 1, S4, C_IDLE, 1), 1020);

    // clr during ADD's T5 aborts to T1
    apply(mk(0, 4'h2, 0, 0, 1, S1, C_T1, 0), 1030);
    apply(mk(0, 4'h2, 0, 0, 1, S2, C_T2, 0), 1031);
    apply(mk(0, 4'h2, 0, 0, 1, S3, C_T3, 0), 1032);
    apply(mk(0, 4'h2, 0, 0, 1, S4, C_EIM, 0), 1033);
    apply(mk(1, 4'h2, 0, 0, 0, S5, C_IDLE, 0), 1034);
    apply(mk(0, 4'h2, 0, 0, 1, S1, C_T1, 0), 1035);
    apply(mk(0, 4'h2, 0, 0, 1, S2, C_T2, 0), 1036);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap2_mini_ctrl.md
Name: sap2_mini_ctrl

Overview:
- Controller-sequencer for the SAP-2 mini CPU; sits directly downstream of the instruction register `i`.
- Consumes the opcode nibble of the IR output and the ALU flags.
- Runs a one-hot T-state ring counter with variable-length machine cycles and a memory-ready stall.
- Drives the control word that gates every bus load and enable in the datapath, including the IR's own `ln` and `en`.

Parameters:
- CW_W, 16, control word width; bit map fixed in the package.
- T_N, 6, number of T-states, T1..T6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset.
- opcode  input  4  IR out[11:8]; valid from T4 onward.
- flag_z  input  1  ALU zero flag, registered elsewhere.
- flag_c  input  1  ALU carry flag, registered elsewhere.
- mem_rdy  input  1  RAM ready; low stretches memory states.
- cw  output  CW_W  control word; decoded combinationally from t_state, opcode and flags.
- t_state  output  T_N  one-hot ring counter, registered.
- halted  output  1  high while in halt, registered.

Behaviour:
- Reset: clr sampled high at an edge gives t_state=6'b000001 (T1) and halted=0. While clr is high, cw is forced to CW_IDLE (16'h0C54: active-low loads high, all else low). clr mid-instruction aborts the instruction; no partial write persists beyond the current cycle.
- Control word bit map, bits 0..15: CP, EP, LM_n, CE, LI_n, EI, LA_n, EA, SU, EU, LB_n, LO_n, J, WE, FI, HLT. Suffix _n means active-low load; all other bits are active-high.
- Fetch, common to all opcodes:
  - T1: EP, LM_n.
  - T2: CP.
  - T3: CE, LI_n. The IR captures on the T3→T4 edge.
- Execute, T4..T6. Unlisted states are not entered; end of instruction means next state is T1.
  - 0 NOP: T4 idle, then end.
  - 1 LDA: T4 EI,LM_n; T5 CE,LA_n; end.
  - 2 ADD: T4 EI,LM_n; T5 CE,LB_n; T6 EU,LA_n,FI; end.
  - 3 SUB: same as ADD, with SU added in T6.
  - 4 STA: T4 EI,LM_n; T5 EA,WE; end.
  - 5 LDI: T4 EI,LA_n; end.
  - 6 JMP: T4 EI,J; end.
  - 7 JC: T4 EI,J if flag_c, else idle; end.
  - 8 JZ: T4 EI,J if flag_z, else idle; end.
  - E OUT: T4 EA,LO_n; end.
  - F HLT: T4 HLT; then halted=1 and t_state holds T4 with cw HLT asserted until clr.
  - 9..D undefined: behave as NOP.
- Memory stall:
  - Applies in T3, and in T5 of LDA/ADD/SUB/STA.
  - If mem_rdy=0 at the edge, t_state holds and cw is repeated unchanged.
  - WE stays asserted through the stall; the write completes on the edge where mem_rdy=1.
- mem_rdy is ignored in all non-memory states.
- Flags are sampled combinationally in T4 only. Flag changes in other states have no effect.
- Simultaneous events:
  - clr beats stall and halt.
  - A stall in the final state of an instruction delays the return to T1.
- Invariant: exactly one t_state bit is high. Illegal encodings recover to T1 on the next edge.
- Instruction length in clocks, no stalls: 4 for NOP/LDI/JMP/JC/JZ/OUT; 5 for LDA/STA; 6 for ADD/SUB.

Decomposition:
- sap2_mini_pkg holds:
  - opcode constants;
  - CW bit-index constants;
  - CW_IDLE;
  - one-hot T-state constants T1..T6.
- Sub-module sap2_mini_ring: one-hot ring counter with inputs hold (stall/halt), restart (end of instruction) and clr.
- sap2_mini_ctrl contains only the decode and next-state logic around sap2_mini_ring.

Test Plan:
1. Reset: clr=1 for 2 edges, then release → t_state=000001, cw=16'h0C54 while clr is high; after release, T1 cw = EP|LM_n asserted (bit2 low, bit1 high).
2. LDI (opcode 5), mem_rdy=1 → states T1,T2,T3,T4,T1 over 4 clocks; cw in T4 has EI=1, LA_n=0.
3. ADD (opcode 2) → 6-clock cycle; T6 cw has EU=1, LA_n=0, FI=1, SU=0. SUB (opcode 3) → same with SU=1.
4. JC (opcode 7): flag_c=1 → J=1 in T4. flag_c=0 → J=0 and the instruction still ends after T4. Repeat for JZ with flag_z.
5. STA with mem_rdy low for 3 edges in T5 → t_state holds T5 for 4 cycles with WE=1 throughout, then T1.
6. HLT (opcode F) → halted=1 from the T4 edge and t_state frozen at T4 for 10 clocks. clr asserted during an ADD's T5 → next state T1, halted=0.
